mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory/cache slave between instruction fetch (I, read-only)
//  and the load/store unit (D, read/write). Request/waitrequest handshake on every side.
//  Zero-bubble combinational grant when idle; the grant is locked while a transfer waits.
//  Selectable arbitration policy, with an anti-starvation limit for fetch.
// PARAMETERS
//  ADDR_WIDTH  32  address width, all ports
//  DATA_WIDTH  32  data width, all ports
//  RR_MODE     0   0 = D fixed priority over I; 1 = round-robin on conflict
//  MAX_STREAK  4   fixed-priority mode: max consecutive D grants while I waits (1..15)
// PORTS
//  clock          in   1           rising-edge clock
//  reset          in   1           synchronous, active-high reset
//  i_addr         in   ADDR_WIDTH  fetch address
//  i_rd           in   1           fetch read request
//  i_rdata        out  DATA_WIDTH  fetch read data, valid when i_rd & ~i_waitrequest
//  i_waitrequest  out  1           fetch stall
//  d_addr         in   ADDR_WIDTH  data address
//  d_rd / d_wr    in   1 / 1       data read / write request
//  d_wdata        in   DATA_WIDTH  write data
//  d_be           in   DATA_WIDTH/8 byte enables (writes)
//  d_rdata        out  DATA_WIDTH  data read data, valid when d_rd & ~d_waitrequest
//  d_waitrequest  out  1           data stall
//  m_addr, m_rd, m_wr, m_wdata, m_be  out  --  forwarded to slave (widths as D side)
//  m_rdata        in   DATA_WIDTH  slave read data, valid in cycle m_waitrequest=0
//  m_waitrequest  in   1           slave stall
//  owner          out  2           00 none, 01 I, 10 D (current cycle's forwarded master)
// BEHAVIOUR
//  State: IDLE, LOCK_I, LOCK_D. Streak counter: 4 bits. last_owner: 1 bit.
//  Reset: state=IDLE, streak=0, last_owner=I.
//   During reset, the outputs are forced as follows: m_rd=m_wr=0, i/d_waitrequest=1, owner=00.
//  Requesters hold addr/data/request stable until their waitrequest is 0 (handshake rule).
//  d_req = d_rd|d_wr. If d_rd and d_wr are both set, the request is a write and d_rd is ignored.
//  IDLE: pick a winner combinationally; its request is forwarded to m_* in the same cycle.
//   - Only one requester: it wins.
//   - Both, RR_MODE=1: the master that is not last_owner wins.
//   - Both, RR_MODE=0: D wins, unless streak==MAX_STREAK, in which case I wins.
//  LOCK_x: only x is forwarded. Arbitration is frozen until completion.
//  Completion = the forwarded request is active and m_waitrequest=0.
//   - In the completion cycle, the winner's waitrequest=0 and its rdata=m_rdata.
//   - The next state is IDLE, so a new arbitration happens every transfer (no bubble cycle).
//  Winner in IDLE with m_waitrequest=1: next state is LOCK_winner.
//  The loser, and any idle side, sees waitrequest=1. Its rdata is don't-care (driven m_rdata).
//  m_* when nothing is forwarded: m_rd=m_wr=0, m_addr/wdata/be=0.
//  last_owner is updated on every completion.
//  streak (fixed-priority mode only):
//   - +1 on a D completion while i_rd=1, saturating at MAX_STREAK.
//   - Cleared on an I completion or whenever i_rd=0.
//  Single-cycle slave (m_waitrequest tied 0): the FSM never leaves IDLE. Throughput: 1 transfer/cycle.
//  Requester drops its request while in LOCK (protocol violation): return to IDLE next cycle.
//   No m_* transfer is issued for it. Sim-only assertion fires.
//  Reset asserted mid-transfer: the transfer is abandoned and no completion is reported.
//  Latency: zero added cycles. Every path from request to m_* and from m_* to response is combinational.
// TESTING
//  1 Only i_rd, addr 0x100, slave wait 2 cycles -> m_rd at 0x100 for 3 cycles.
//    i_waitrequest=1,1,0. i_rdata=m_rdata in the 3rd cycle. owner=01 throughout.
//  2 i_rd & d_wr same cycle, RR_MODE=0, zero-wait slave -> D granted.
//    m_wr=1, m_be=d_be, i_waitrequest=1. The next cycle grants I.
//  3 RR_MODE=0, MAX_STREAK=4, continuous D and I requests, zero-wait slave.
//    Required grant order: D,D,D,D,I,D,D,D,D,I.
//  4 RR_MODE=1, continuous D and I requests, last_owner=I after reset.
//    Required grant order: D,I,D,I. Each grant completes in 1 cycle.
//  5 D granted with the slave stalling. Assert i_rd mid-wait.
//    The grant stays D (owner=10) until m_waitrequest=0, then I is forwarded the next cycle.
//  6 reset pulsed during LOCK_D -> m_rd=m_wr=0 during reset.
//    After release: state IDLE, streak 0. The next request is arbitrated afresh.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported slave between instruction fetch
// (read-only) and the load/store unit (read/write). The grant is decided
// combinationally while idle and then locked until the slave completes, so
// no cycles are added on either the request or the response path.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RR_MODE    = 0,   // 0: D has priority, 1: alternate on conflict
    parameter int MAX_STREAK = 4    // D grants in a row allowed while I waits (1..15)
) (
    input  logic                    clock,
    input  logic                    reset,
    // instruction fetch side
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic                    i_rd,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_waitrequest,
    // load/store side
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic                    d_rd,
    input  logic                    d_wr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_waitrequest,
    // shared slave
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic                    m_rd,
    output logic                    m_wr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_be,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic                    m_waitrequest,
    output logic [1:0]              owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    state_t     state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic       last_owner_q, last_owner_d;   // 0 = I, 1 = D

    logic d_req;
    logic grant_i;
    logic grant_d;
    logic done;

    // A simultaneous read and write from D is treated as a write.
    assign d_req = d_rd | d_wr;

    // Pick this cycle's forwarded master: free arbitration in IDLE, frozen in LOCK.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (i_rd && d_req) begin
                        if (RR_MODE != 0) begin
                            grant_i = ~last_owner_q ? 1'b0 : 1'b1;
                            grant_d = ~last_owner_q;
                        end else if (streak_q == STREAK_MAX) begin
                            grant_i = 1'b1;
                        end else begin
                            grant_d = 1'b1;
                        end
                    end else begin
                        grant_i = i_rd;
                        grant_d = d_req;
                    end
                end
                LOCK_I:  grant_i = i_rd;
                LOCK_D:  grant_d = d_req;
                default: ;
            endcase
        end
    end

    // Forward the granted request to the slave and route the response back.
    always_comb begin
        m_rd          = grant_i | (grant_d & d_rd & ~d_wr);
        m_wr          = grant_d & d_wr;
        m_addr        = '0;
        m_wdata       = '0;
        m_be          = '0;
        if (grant_i) begin
            m_addr    = i_addr;
        end else if (grant_d) begin
            m_addr    = d_addr;
            m_wdata   = d_wdata;
            m_be      = d_be;
        end
        done          = (grant_i | grant_d) & ~m_waitrequest;
        i_waitrequest = ~(grant_i & done);
        d_waitrequest = ~(grant_d & done);
        i_rdata       = m_rdata;
        d_rdata       = m_rdata;
        owner         = {grant_d, grant_i};
    end

    // Next state: lock onto a stalled winner, return to IDLE on completion or a dropped request.
    always_comb begin
        state_d      = IDLE;
        streak_d     = streak_q;
        last_owner_d = last_owner_q;
        if (done) begin
            state_d = IDLE;
        end else if (grant_i) begin
            state_d = LOCK_I;
        end else if (grant_d) begin
            state_d = LOCK_D;
        end
        if (done) begin
            last_owner_d = grant_d;
        end
        if (RR_MODE == 0) begin
            if (!i_rd || (done && grant_i)) begin
                streak_d = 4'd0;
            end else if (done && grant_d && (streak_q != STREAK_MAX)) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    // State, streak and last-owner registers; reset abandons any transfer in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            streak_q     <= 4'd0;
            last_owner_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            last_owner_q <= last_owner_d;
        end
    end

    // A locked requester must keep its request up until the slave completes it.
    a_hold_i: assert property (@(posedge clock) disable iff (reset)
        (state_q == LOCK_I) |-> i_rd);
    a_hold_d: assert property (@(posedge clock) disable iff (reset)
        (state_q == LOCK_D) |-> d_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed stimulus pushes the expected transfer
// of every completion into a queue; a monitor pops and compares on each
// completion it observes. Two instances cover fixed-priority and round-robin.
module tb_mem_port_arbiter;

    localparam logic [1:0] OWN_I = 2'b01;
    localparam logic [1:0] OWN_D = 2'b10;

    typedef struct packed {
        logic [1:0]  owner;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_rd, d_rd, d_wr;
    logic [3:0]  d_be;
    logic        slv_wait;
    logic        sel_rr;

    // fixed-priority instance
    logic [31:0] i_rdata_fp, d_rdata_fp, m_addr_fp, m_wdata_fp, m_rdata_fp;
    logic        i_wait_fp, d_wait_fp, m_rd_fp, m_wr_fp;
    logic [3:0]  m_be_fp;
    logic [1:0]  owner_fp;
    // round-robin instance
    logic [31:0] i_rdata_rr, d_rdata_rr, m_addr_rr, m_wdata_rr, m_rdata_rr;
    logic        i_wait_rr, d_wait_rr, m_rd_rr, m_wr_rr;
    logic [3:0]  m_be_rr;
    logic [1:0]  owner_rr;

    // slave model: read data is the inverted address
    assign m_rdata_fp = ~m_addr_fp;
    assign m_rdata_rr = ~m_addr_rr;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(0), .MAX_STREAK(4)) dut_fp (
        .clock(clock), .reset(reset),
        .i_addr(i_addr), .i_rd(i_rd), .i_rdata(i_rdata_fp), .i_waitrequest(i_wait_fp),
        .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata_fp), .d_waitrequest(d_wait_fp),
        .m_addr(m_addr_fp), .m_rd(m_rd_fp), .m_wr(m_wr_fp), .m_wdata(m_wdata_fp), .m_be(m_be_fp),
        .m_rdata(m_rdata_fp), .m_waitrequest(slv_wait), .owner(owner_fp)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1), .MAX_STREAK(4)) dut_rr (
        .clock(clock), .reset(reset),
        .i_addr(i_addr), .i_rd(i_rd), .i_rdata(i_rdata_rr), .i_waitrequest(i_wait_rr),
        .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata_rr), .d_waitrequest(d_wait_rr),
        .m_addr(m_addr_rr), .m_rd(m_rd_rr), .m_wr(m_wr_rr), .m_wdata(m_wdata_rr), .m_be(m_be_rr),
        .m_rdata(m_rdata_rr), .m_waitrequest(slv_wait), .owner(owner_rr)
    );

    // monitored view: whichever instance the current test targets
    logic [31:0] mon_i_rdata, mon_d_rdata, mon_m_addr, mon_m_wdata;
    logic        mon_iw, mon_dw, mon_m_rd, mon_m_wr;
    logic [3:0]  mon_m_be;
    logic [1:0]  mon_owner;
    assign mon_i_rdata = sel_rr ? i_rdata_rr : i_rdata_fp;
    assign mon_d_rdata = sel_rr ? d_rdata_rr : d_rdata_fp;
    assign mon_m_addr  = sel_rr ? m_addr_rr  : m_addr_fp;
    assign mon_m_wdata = sel_rr ? m_wdata_rr : m_wdata_fp;
    assign mon_iw      = sel_rr ? i_wait_rr  : i_wait_fp;
    assign mon_dw      = sel_rr ? d_wait_rr  : d_wait_fp;
    assign mon_m_rd    = sel_rr ? m_rd_rr    : m_rd_fp;
    assign mon_m_wr    = sel_rr ? m_wr_rr    : m_wr_fp;
    assign mon_m_be    = sel_rr ? m_be_rr    : m_be_fp;
    assign mon_owner   = sel_rr ? owner_rr   : owner_fp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic push_rd(input logic [1:0] own, input logic [31:0] a);
        exp_t e;
        e.owner = own; e.wr = 1'b0; e.addr = a; e.data = ~a; e.be = 4'h0;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [1:0] own, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        e.owner = own; e.wr = 1'b1; e.addr = a; e.data = wd; e.be = be;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every visible completion must match the head of the queue.
    always @(negedge clock) begin
        if (reset === 1'b0 && ((i_rd && !mon_iw) || ((d_rd || d_wr) && !mon_dw))) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion got owner=%b addr=%h expected none t=%0t",
                         mon_owner, mon_m_addr, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("owner", 32'(mon_owner), 32'(e.owner));
                chk("m_addr", mon_m_addr, e.addr);
                chk("m_rd_wr", 32'({mon_m_wr, mon_m_rd}), e.wr ? 32'd2 : 32'd1);
                if (e.wr) begin
                    chk("m_wdata", mon_m_wdata, e.data);
                    chk("m_be", 32'(mon_m_be), 32'(e.be));
                end else begin
                    chk("rdata", (e.owner == OWN_I) ? mon_i_rdata : mon_d_rdata, e.data);
                end
                $display("txn owner=%b wr=%0d addr=%h", e.owner, e.wr, e.addr);
            end
        end
    end

    initial begin
        reset = 1'b1; sel_rr = 1'b0; slv_wait = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
        i_rd = 1'b1; d_rd = 1'b0; d_wr = 1'b1;          // requests held during reset
        step(); step();
        @(negedge clock);
        chk("rst_m_rd", 32'(m_rd_fp), 32'd0);
        chk("rst_m_wr", 32'(m_wr_fp), 32'd0);
        chk("rst_i_wait", 32'(i_wait_fp), 32'd1);
        chk("rst_d_wait", 32'(d_wait_fp), 32'd1);
        chk("rst_owner", 32'(owner_fp), 32'd0);
        step();
        reset = 1'b0; i_rd = 1'b0; d_wr = 1'b0;
        @(negedge clock);
        chk("idle_owner", 32'(owner_fp), 32'd0);
        chk("idle_m_rd", 32'(m_rd_fp), 32'd0);
        chk("idle_m_addr", m_addr_fp, 32'd0);

        // 1: fetch only, slave waits two cycles
        step();
        i_addr = 32'h100; i_rd = 1'b1; slv_wait = 1'b1;
        push_rd(OWN_I, 32'h100);
        @(negedge clock);
        chk("t1_iwait_c1", 32'(i_wait_fp), 32'd1);
        chk("t1_owner_c1", 32'(owner_fp), 32'(OWN_I));
        chk("t1_m_rd_c1", 32'(m_rd_fp), 32'd1);
        chk("t1_addr_c1", m_addr_fp, 32'h100);
        step();
        @(negedge clock);
        chk("t1_iwait_c2", 32'(i_wait_fp), 32'd1);
        chk("t1_owner_c2", 32'(owner_fp), 32'(OWN_I));
        step();
        slv_wait = 1'b0;
        @(negedge clock);
        chk("t1_iwait_c3", 32'(i_wait_fp), 32'd0);
        chk("t1_rdata_c3", i_rdata_fp, 32'hFFFF_FEFF);
        step();
        i_rd = 1'b0;

        // 2: fetch and write collide, D wins, then I
        i_addr = 32'h200; i_rd = 1'b1;
        d_addr = 32'h300; d_wr = 1'b1; d_wdata = 32'h1234_5678; d_be = 4'b0101;
        push_wr(OWN_D, 32'h300, 32'h1234_5678, 4'b0101);
        @(negedge clock);
        chk("t2_iwait", 32'(i_wait_fp), 32'd1);
        chk("t2_m_wr", 32'(m_wr_fp), 32'd1);
        chk("t2_m_be", 32'(m_be_fp), 32'h5);
        step();
        d_wr = 1'b0;
        push_rd(OWN_I, 32'h200);
        @(negedge clock);
        chk("t2_owner_next", 32'(owner_fp), 32'(OWN_I));
        step();
        i_rd = 1'b0;
        step();

        // 3: fixed priority with streak limit: D,D,D,D,I,D,D,D,D,I
        d_addr = 32'h400; d_rd = 1'b1; i_addr = 32'h500; i_rd = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push_rd(OWN_D, 32'h400);
            push_rd(OWN_I, 32'h500);
        end
        repeat (10) step();
        d_rd = 1'b0; i_rd = 1'b0;

        // 4: round-robin from reset: D,I,D,I
        reset = 1'b1;
        step();
        reset = 1'b0; sel_rr = 1'b1;
        d_addr = 32'h440; d_rd = 1'b1; i_addr = 32'h550; i_rd = 1'b1;
        push_rd(OWN_D, 32'h440); push_rd(OWN_I, 32'h550);
        push_rd(OWN_D, 32'h440); push_rd(OWN_I, 32'h550);
        repeat (4) step();
        d_rd = 1'b0; i_rd = 1'b0;
        step();
        sel_rr = 1'b0;

        // 5: D locked while stalling, I arrives mid-wait
        d_addr = 32'h600; d_rd = 1'b1; slv_wait = 1'b1;
        @(negedge clock);
        chk("t5_owner_c1", 32'(owner_fp), 32'(OWN_D));
        step();
        i_addr = 32'h700; i_rd = 1'b1;
        @(negedge clock);
        chk("t5_owner_c2", 32'(owner_fp), 32'(OWN_D));
        chk("t5_iwait_c2", 32'(i_wait_fp), 32'd1);
        chk("t5_addr_c2", m_addr_fp, 32'h600);
        step();
        @(negedge clock);
        chk("t5_owner_c3", 32'(owner_fp), 32'(OWN_D));
        step();
        slv_wait = 1'b0;
        push_rd(OWN_D, 32'h600);
        step();
        d_rd = 1'b0;
        push_rd(OWN_I, 32'h700);
        step();
        i_rd = 1'b0;
        step();

        // 6: build a streak of 3, stall, reset mid-lock; streak must restart at 0
        i_addr = 32'h900; i_rd = 1'b1; d_addr = 32'hA00; d_rd = 1'b1;
        for (int k = 0; k < 3; k++) push_rd(OWN_D, 32'hA00);
        repeat (3) step();
        slv_wait = 1'b1;
        @(negedge clock);
        chk("t6_owner_lock", 32'(owner_fp), 32'(OWN_D));
        chk("t6_m_rd_lock", 32'(m_rd_fp), 32'd1);
        step();
        reset = 1'b1;
        @(negedge clock);
        chk("t6_rst_m_rd", 32'(m_rd_fp), 32'd0);
        chk("t6_rst_m_wr", 32'(m_wr_fp), 32'd0);
        chk("t6_rst_owner", 32'(owner_fp), 32'd0);
        chk("t6_rst_dwait", 32'(d_wait_fp), 32'd1);
        step();
        reset = 1'b0; slv_wait = 1'b0;
        for (int k = 0; k < 4; k++) push_rd(OWN_D, 32'hA00);
        push_rd(OWN_I, 32'h900);
        repeat (5) step();
        i_rd = 1'b0; d_rd = 1'b0;
        step();
        @(negedge clock);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
